// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states and
// the accept-time fault rule.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Rejected before any memory strobe: bad size, misalignment, or store into ROM.
    function automatic logic access_fault(
        input logic [1:0] size,
        input logic [1:0] addr_lo,
        input logic       write,
        input logic       ram_sel
    );
        logic bad;
        bad = 1'b0;
        if (size == SIZE_ILL)                          bad = 1'b1;
        if (size == SIZE_HALF && addr_lo[0])           bad = 1'b1;
        if (size == SIZE_WORD && addr_lo != 2'b00)     bad = 1'b1;
        if (write && !ram_sel)                         bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: merges a sub-word store into a fetched word and
// extracts/extends a load lane (little-endian lanes).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_word,
    output logic [31:0] o_merged_word,
    output logic [31:0] o_load_data
);

    logic [31:0] w_store_rep;
    logic [3:0]  w_lane_en;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Replicate the right-aligned store data across every lane it could target.
    always_comb begin
        w_store_rep = i_store_data;
        case (i_size)
            SIZE_BYTE: w_store_rep = {4{i_store_data[7:0]}};
            SIZE_HALF: w_store_rep = {2{i_store_data[15:0]}};
            default:   w_store_rep = i_store_data;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_en[gi] = (i_size == SIZE_BYTE) ? (i_addr_lo == 2'(gi)) :
                                   (i_size == SIZE_HALF) ? (i_addr_lo[1] == 1'(gi / 2)) :
                                   1'b1;
            assign o_merged_word[gi*8 +: 8] = w_lane_en[gi] ? w_store_rep[gi*8 +: 8]
                                                            : i_mem_word[gi*8 +: 8];
        end
    endgenerate

    assign w_byte = i_mem_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];

    always_comb begin
        o_load_data = i_mem_word;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:   o_load_data = i_mem_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide data memory: one request at a time,
// read-modify-write for sub-word stores, faults decided at accept.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int RAM_SELECT_BIT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqStoreData,
    output logic        respValid,
    output logic [31:0] respLoadData,
    output logic        respFault,
    output logic [31:0] memAddress,
    output logic        memReadEnable,
    output logic        memWriteEnable,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(READ_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_resp_data;

    logic        w_accept;
    logic        w_fault;
    logic        w_read_done;
    logic [31:0] w_merged;
    logic [31:0] w_load;

    assign w_accept    = reqValid && (r_state == IDLE);
    assign w_fault     = access_fault(reqSize, reqAddress[1:0], reqWrite,
                                      reqAddress[RAM_SELECT_BIT]);
    assign w_read_done = (r_state == READ) && (r_cnt == LAST_CNT);

    mem_lane_align u_align (
        .i_size        (r_size),
        .i_addr_lo     (r_addr[1:0]),
        .i_unsigned    (r_unsigned),
        .i_store_data  (r_wdata),
        .i_mem_word    (memDataOut),
        .o_merged_word (w_merged),
        .o_load_data   (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault)                                 w_state_next = RESP;
                    else if (reqWrite && reqSize == SIZE_WORD)   w_state_next = WRITE;
                    else                                         w_state_next = READ;
                end
            end
            READ:    if (w_read_done) w_state_next = r_write ? WRITE : RESP;
            WRITE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // r_wdata holds raw store data until the read completes, then the merged word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fault     <= 1'b0;
            r_cnt       <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_write     <= reqWrite;
                r_size      <= reqSize;
                r_unsigned  <= reqUnsigned;
                r_addr      <= reqAddress;
                r_wdata     <= reqStoreData;
                r_fault     <= w_fault;
                r_resp_data <= '0;
            end
            if (r_state == READ) r_cnt <= r_cnt + 1'b1;
            else                 r_cnt <= '0;
            if (w_read_done) begin
                if (r_write) r_wdata     <= w_merged;
                else         r_resp_data <= w_load;
            end
        end
    end

    assign reqReady       = (r_state == IDLE);
    assign respValid      = (r_state == RESP);
    assign respFault      = respValid && r_fault;
    assign respLoadData   = respValid ? r_resp_data : 32'h0;
    assign memReadEnable  = (r_state == READ);
    assign memWriteEnable = (r_state == WRITE);
    assign memAddress     = (memReadEnable || memWriteEnable) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign memDataIn      = memWriteEnable ? r_wdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of requests with hand-computed
// results against a small RAM/ROM model, plus reset and back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqUnsigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddress, reqStoreData;
    logic        respValid, respFault;
    logic [31:0] respLoadData;
    logic [31:0] memAddress, memDataIn, memDataOut;
    logic        memReadEnable, memWriteEnable;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.READ_LATENCY(1), .RAM_SELECT_BIT(10)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddress(reqAddress),
        .reqStoreData(reqStoreData), .respValid(respValid),
        .respLoadData(respLoadData), .respFault(respFault),
        .memAddress(memAddress), .memReadEnable(memReadEnable),
        .memWriteEnable(memWriteEnable), .memDataIn(memDataIn),
        .memDataOut(memDataOut)
    );

    always #5 clk = ~clk;

    // RAM words at 0x400-0x7FF; ROM returns a fixed address-derived pattern.
    logic [31:0] ram [0:255];
    always @(posedge clk) if (memWriteEnable && memAddress[10]) ram[memAddress[9:2]] <= memDataIn;
    assign memDataOut = memAddress[10] ? ram[memAddress[9:2]]
                                       : (32'hC0DE_0000 | {16'h0, memAddress[15:0]});

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [0:NV-1];

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] ed, input logic ef, input int lat,
                                input int rd, input int wn, input logic [31:0] em);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.sd = sd;
        v.exp_data = ed; v.exp_fault = ef; v.exp_lat = lat;
        v.exp_rd = rd; v.exp_wr = wn; v.exp_mem = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!reqReady && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {31'b0, reqReady}, 32'h1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, rd, wn, bad;
        logic got;
        logic [31:0] data;
        logic fault;
        wait_ready();
        reqWrite = v.wr; reqSize = v.sz; reqUnsigned = v.uns;
        reqAddress = v.addr; reqStoreData = v.sd; reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqWrite = ~v.wr; reqSize = 2'b11; reqUnsigned = ~v.uns;
        reqAddress = 32'h0; reqStoreData = ~v.sd;
        lat = 0; rd = 0; wn = 0; bad = 0; got = 1'b0; data = 32'h0; fault = 1'b0;
        while (!got && lat < 20) begin
            lat++;
            @(negedge clk);
            if (memReadEnable) rd++;
            if (memWriteEnable) wn++;
            if (memReadEnable || memWriteEnable) begin
                if (memAddress !== {v.addr[31:2], 2'b00}) bad++;
            end else if (memAddress !== 32'h0) bad++;
            if (respValid) begin
                got = 1'b1; data = respLoadData; fault = respFault;
            end
        end
        n_vec++;
        chk("resp_seen", {31'b0, got}, 32'h1);
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("load_data", data, v.exp_data);
        chk("fault", {31'b0, fault}, {31'b0, v.exp_fault});
        chk("read_strobes", 32'(rd), 32'(v.exp_rd));
        chk("write_strobes", 32'(wn), 32'(v.exp_wr));
        chk("mem_address", 32'(bad), 32'h0);
        if (v.wr && !v.exp_fault) chk("ram_word", ram[v.addr[9:2]], v.exp_mem);
        $display("vec %0d: wr=%0d size=%0d addr=0x%08h -> data=0x%08h fault=%0d lat=%0d",
                 idx, v.wr, v.sz, v.addr, data, fault, lat);
    endtask

    initial begin
        logic [6:0]  rdy_seq, rv_seq;
        logic [31:0] d1, d2;
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqUnsigned = 1'b0; reqAddress = 32'h0; reqStoreData = 32'h0;

        //            wr    size  uns   addr          sd            data          flt lat rd wr mem
        vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF);
        vecs[1]  = mk(1'b1, 2'b00, 1'b0, 32'h402, 32'h00000055, 32'h0,        1'b0, 3, 1, 1, 32'hDE55BEEF);
        vecs[2]  = mk(1'b0, 2'b00, 1'b0, 32'h401, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0, 32'h0);
        vecs[3]  = mk(1'b0, 2'b00, 1'b1, 32'h401, 32'h0,        32'h000000BE, 1'b0, 2, 1, 0, 32'h0);
        vecs[4]  = mk(1'b0, 2'b01, 1'b0, 32'h402, 32'h0,        32'hFFFFDE55, 1'b0, 2, 1, 0, 32'h0);
        vecs[5]  = mk(1'b0, 2'b01, 1'b1, 32'h400, 32'h0,        32'h0000BEEF, 1'b0, 2, 1, 0, 32'h0);
        vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'hDE55BEEF, 1'b0, 2, 1, 0, 32'h0);
        vecs[7]  = mk(1'b0, 2'b00, 1'b0, 32'h403, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0);
        vecs[8]  = mk(1'b0, 2'b10, 1'b0, 32'h402, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[9]  = mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[10] = mk(1'b0, 2'b11, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[11] = mk(1'b0, 2'b01, 1'b0, 32'h401, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[12] = mk(1'b1, 2'b00, 1'b0, 32'h200, 32'h000000AA, 32'h0,        1'b1, 1, 0, 0, 32'h0);
        vecs[13] = mk(1'b1, 2'b10, 1'b0, 32'h404, 32'h01020304, 32'h0,        1'b0, 2, 0, 1, 32'h01020304);
        vecs[14] = mk(1'b1, 2'b01, 1'b0, 32'h406, 32'h0000A5A5, 32'h0,        1'b0, 3, 1, 1, 32'hA5A50304);
        vecs[15] = mk(1'b1, 2'b00, 1'b0, 32'h405, 32'hFFFFFF80, 32'h0,        1'b0, 3, 1, 1, 32'hA5A58004);
        vecs[16] = mk(1'b0, 2'b01, 1'b0, 32'h404, 32'h0,        32'hFFFF8004, 1'b0, 2, 1, 0, 32'h0);
        vecs[17] = mk(1'b0, 2'b00, 1'b0, 32'h406, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 1, 0, 32'h0);
        vecs[18] = mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hC0DE0100, 1'b0, 2, 1, 0, 32'h0);
        vecs[19] = mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'hFFFFFFC0, 1'b0, 2, 1, 0, 32'h0);
        vecs[20] = mk(1'b0, 2'b00, 1'b1, 32'h102, 32'h0,        32'h000000DE, 1'b0, 2, 1, 0, 32'h0);
        vecs[21] = mk(1'b1, 2'b10, 1'b0, 32'h408, 32'h11223344, 32'h0,        1'b0, 2, 0, 1, 32'h11223344);
        vecs[22] = mk(1'b1, 2'b01, 1'b0, 32'h40A, 32'h12347777, 32'h0,        1'b0, 3, 1, 1, 32'h77773344);

        #1;
        n_vec++;
        chk("reset_ctrl", {27'b0, reqReady, respValid, respFault, memReadEnable, memWriteEnable},
            32'h10);
        chk("reset_data", memAddress | memDataIn | respLoadData, 32'h0);
        $display("reset: reqReady=%0d respValid=%0d memAddress=0x%08h", reqReady, respValid, memAddress);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset while the read half of a byte store is in flight.
        wait_ready();
        reqWrite = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddress = 32'h408; reqStoreData = 32'h99; reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        n_vec++;
        chk("rmw_in_read", {31'b0, memReadEnable}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_ctrl", {27'b0, reqReady, respValid, respFault, memReadEnable, memWriteEnable},
            32'h10);
        chk("midreset_data", memAddress | memDataIn | respLoadData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_ram", ram[8'h02], 32'h77773344);
        chk("midreset_ready", {31'b0, reqReady}, 32'h1);
        $display("reset-mid-rmw: ram[0x408]=0x%08h reqReady=%0d", ram[8'h02], reqReady);

        // reqValid held high: second load accepted the cycle after RESP.
        wait_ready();
        reqWrite = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddress = 32'h400; reqStoreData = 32'h0; reqValid = 1'b1;
        d1 = 32'h0; d2 = 32'h0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            rdy_seq[i] = reqReady;
            rv_seq[i]  = respValid;
            if (i == 2) d1 = respLoadData;
            if (i == 5) d2 = respLoadData;
            if (i == 6) reqValid = 1'b0;
        end
        n_vec++;
        chk("b2b_ready", {25'b0, rdy_seq}, 32'h49);
        chk("b2b_resp", {25'b0, rv_seq}, 32'h24);
        chk("b2b_data1", d1, 32'hDE55BEEF);
        chk("b2b_data2", d2, 32'hDE55BEEF);
        $display("back-to-back: ready=%b resp=%b data=0x%08h/0x%08h", rdy_seq, rv_seq, d1, d2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
